// File: rtl/onehot_encoder_8x3_seq_if.sv
// Stream bundle for onehot_encoder_8x3_seq: request vector in, encoded codes out.
// Optional out_last is present only when ENC_LAST_EN is defined.
interface onehot_encoder_8x3_seq_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_code;
    logic             drop;
    logic [CNT_W-1:0] code_cnt;
`ifdef ENC_LAST_EN
    logic             out_last;
`endif

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  drop,
`ifdef ENC_LAST_EN
        input  out_last,
`endif
        input  code_cnt
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code,
        output drop,
`ifdef ENC_LAST_EN
        output out_last,
`endif
        output code_cnt
    );
endinterface

// File: rtl/onehot_encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: emits the code of every set request bit, lowest code first.
// Define ENC_LAST_EN to add out_last, flagging the final code of each vector.
module onehot_encoder_8x3_seq #(
    parameter bit CODE_MAP = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_encoder_8x3_seq_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_pend;
    logic [7:0]       w_pend_nxt;
    logic             r_drop;
    logic             w_drop_nxt;
    logic [CNT_W-1:0] r_code_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_code;
    logic [2:0]       w_sel_idx;
    logic [7:0]       w_sel_mask;

    function automatic logic [2:0] code_to_idx(input logic [2:0] code);
        logic [2:0] idx;
        if (CODE_MAP) begin
            idx = 3'd7 - code;
        end else begin
            idx = code;
        end
        return idx;
    endfunction

    // Pick the pending bit with the lowest code; scanning high-to-low lets the last hit win.
    always_comb begin
        w_code    = 3'd0;
        w_sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_pend[code_to_idx(3'(i))]) begin
                w_code    = 3'(i);
                w_sel_idx = code_to_idx(3'(i));
            end else begin
                w_code    = w_code;
                w_sel_idx = w_sel_idx;
            end
        end
        w_sel_mask = 8'd1 << w_sel_idx;
    end

    // Next-state, pending-vector, drop and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_drop_nxt  = 1'b0;
        w_cnt_nxt   = r_code_cnt;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_vec != 8'd0) begin
                        w_pend_nxt  = bus.in_vec;
                        w_state_nxt = SCAN;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    w_pend_nxt = r_pend & ~w_sel_mask;
                    w_cnt_nxt  = r_code_cnt + CNT_W'(1);
                    if (w_pend_nxt == 8'd0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = SCAN;
                    end
                end else begin
                    w_state_nxt = SCAN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pend_nxt  = 8'd0;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pend     <= 8'd0;
            r_drop     <= 1'b0;
            r_code_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_drop     <= w_drop_nxt;
            r_code_cnt <= w_cnt_nxt;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == SCAN);
    assign bus.out_code  = (r_state == SCAN) ? w_code : 3'd0;
    assign bus.drop      = r_drop;
    assign bus.code_cnt  = r_code_cnt;
`ifdef ENC_LAST_EN
    assign bus.out_last  = (r_state == SCAN) && ((r_pend & (r_pend - 8'd1)) == 8'd0);
`endif
endmodule

// File: tb/tb_onehot_encoder_8x3_seq.sv
// Randomized self-checking bench for onehot_encoder_8x3_seq against a queue-based model.
// Honors ENC_LAST_EN when defined.
module tb_onehot_encoder_8x3_seq;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    onehot_encoder_8x3_seq_if #(.CNT_W(CW)) bus ();

    onehot_encoder_8x3_seq #(.CODE_MAP(1'b1), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          q[$];
    logic [CW-1:0] m_cnt;
    logic        m_drop;
    logic [7:0]  acc;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Codes of a vector in ascending order; code c names bit 7-c.
    task automatic model_push(input logic [7:0] v);
        for (int c = 0; c < 8; c++) begin
            if (v[7-c]) q.push_back(c);
        end
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check_eq("in_ready",  32'(bus.in_ready),  32'(q.size() == 0));
        check_eq("out_code",  32'(bus.out_code),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check_eq("drop",      32'(bus.drop),      32'(m_drop));
        check_eq("code_cnt",  32'(bus.code_cnt),  32'(m_cnt));
`ifdef ENC_LAST_EN
        check_eq("out_last",  32'(bus.out_last),  32'(q.size() == 1));
`endif
    endtask

    task automatic step();
        logic nd;
        nd = 1'b0;
        if (bus.out_valid && bus.out_ready) acc = acc | (8'h80 >> bus.out_code);
        @(posedge clk);
        if (q.size() == 0) begin
            if (bus.in_valid) begin
                if (bus.in_vec == 8'd0) nd = 1'b1;
                else model_push(bus.in_vec);
            end
        end else if (bus.out_ready) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        m_drop = nd;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        m_cnt  = '0;
        m_drop = 1'b0;
        check_outputs();
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        bus.in_valid = 1'b0;
        bus.in_vec   = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] v, input logic rdy);
        bus.in_valid  = 1'b1;
        bus.in_vec    = v;
        bus.out_ready = rdy;
        step();
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = 8'h00;
        bus.out_ready = 1'b0;
        acc           = 8'h00;
        @(negedge clk);
        do_reset();

        // Single top bit, then a sparse vector.
        send(8'h80, 1'b1);
        repeat (2) step();
        check_eq("t2_cnt", 32'(bus.code_cnt), 32'd1);
        send(8'hA5, 1'b1);
        repeat (5) step();
        check_eq("t3_cnt", 32'(bus.code_cnt), 32'd5);

        // Back-pressure holds code 6 stable.
        send(8'h03, 1'b0);
        repeat (3) step();
        check_eq("t4_hold", 32'(bus.out_code), 32'd6);
        bus.out_ready = 1'b1;
        repeat (3) step();

        // Zero vector, then in_valid held across a full scan.
        send(8'h00, 1'b1);
        step();
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'hFF;
        repeat (10) step();
        bus.in_valid = 1'b0;
        repeat (10) step();

        // Reset mid-scan.
        send(8'hF0, 1'b1);
        repeat (2) step();
        do_reset();
        check_eq("t6_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t6_cnt",   32'(bus.code_cnt),  32'd0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_vec    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end
        bus.in_valid = 1'b0;

        // Every vector rebuilds through a decoder3x8 model.
        for (int v = 0; v < 256; v++) begin
            bus.out_ready = 1'b1;
            guard = 0;
            while (q.size() != 0 && guard < 20) begin
                step();
                guard++;
            end
            acc = 8'h00;
            send(8'(v), 1'b1);
            guard = 0;
            while (q.size() != 0 && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) check_eq("sweep_timeout", 32'(bus.out_valid), 32'd0);
            check_eq("sweep_or", 32'(acc), 32'(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
